// File: rtl/imem_harness.sv
// Instruction-memory harness: clears, loads, then runs a processor
// against a local program memory with halt, timeout and abort control.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ld_valid/ld_data/ld_last  loader word stream; ld_ready accepts it
//   start, abort              launch/relaunch and stop controls
//   pc, pin_out               processor program counter and output pins
//   ins, cpu_en               fetched instruction, processor clock enable
//   state                     FSM encoding (CLEAR/IDLE/LOAD/RUN/DONE)
//   halted, timeout, load_err status flags
//   prog_len, cycles          last load length, enabled cycles of run

`ifndef BITNESS
`define BITNESS 16
`endif

module imem_harness #(
  parameter int          ADDR_W     = 10,
  parameter int          INS_W      = 16,
  parameter int          PC_W       = `BITNESS,
  parameter int          HALT_BIT   = 0,
  parameter logic [31:0] MAX_CYCLES = 32'd65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [INS_W-1:0]  ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              start,
  input  logic              abort,
  input  logic [PC_W-1:0]   pc,
  input  logic [PC_W-1:0]   pin_out,
  output logic [INS_W-1:0]  ins,
  output logic              cpu_en,
  output logic [2:0]        state,
  output logic              halted,
  output logic              timeout,
  output logic              load_err,
  output logic [ADDR_W:0]   prog_len,
  output logic [31:0]       cycles
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [INS_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] wptr;
  logic              xfer;
  logic              wptr_max;
  logic [ADDR_W:0]   wptr_inc;
  logic [31:0]       cyc_inc;
  logic              hit_max;
  logic              halt;
  logic              unused_bits;

  assign ld_ready = (state == S_IDLE) || (state == S_LOAD);
  assign xfer     = ld_valid && ld_ready;
  assign wptr_max = (wptr == {ADDR_W{1'b1}});
  assign wptr_inc = {1'b0, wptr} + (ADDR_W+1)'(1);

  // cycles saturates so a very long run never wraps back to zero
  assign cyc_inc = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;
  assign hit_max = ({1'b0, cycles} + 33'd1) == {1'b0, MAX_CYCLES};
  assign halt    = pin_out[HALT_BIT];

  assign cpu_en = (state == S_RUN);
  assign ins    = cpu_en ? mem[pc[ADDR_W-1:0]] : '0;

  // remaining pin/pc bits carry no meaning for the harness
  assign unused_bits = ^{pin_out, pc};

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR)
        mem[clr_ptr] <= '0;
      else if (xfer)
        mem[wptr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_CLEAR;
      clr_ptr  <= '0;
      wptr     <= '0;
      prog_len <= '0;
      cycles   <= '0;
      halted   <= 1'b0;
      timeout  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_ptr <= clr_ptr + ADDR_W'(1);
          if (clr_ptr == {ADDR_W{1'b1}}) begin
            state <= S_IDLE;
            wptr  <= '0;
          end
        end
        S_IDLE, S_LOAD: begin
          if (xfer) begin
            if (state == S_IDLE)
              load_err <= 1'b0;
            if (ld_last) begin
              prog_len <= wptr_inc;
              wptr     <= '0;
              state    <= S_IDLE;
            end else if (wptr_max) begin
              load_err <= 1'b1;
              prog_len <= (ADDR_W+1)'(DEPTH);
              wptr     <= '0;
              state    <= S_IDLE;
            end else begin
              wptr  <= wptr + ADDR_W'(1);
              state <= S_LOAD;
            end
          end else if (start && state == S_IDLE) begin
            state   <= S_RUN;
            cycles  <= '0;
            halted  <= 1'b0;
            timeout <= 1'b0;
          end
        end
        S_RUN: begin
          cycles <= cyc_inc;
          // halt beats timeout, which beats abort
          if (halt) begin
            halted <= 1'b1;
            state  <= S_DONE;
          end else if (hit_max) begin
            timeout <= 1'b1;
            state   <= S_DONE;
          end else if (abort) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (start) begin
            state   <= S_RUN;
            cycles  <= '0;
            halted  <= 1'b0;
            timeout <= 1'b0;
          end
        end
        default: begin
          state   <= S_CLEAR;
          clr_ptr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_harness.sv
// Randomized self-checking bench for imem_harness.
// A wide instance covers load/run flows; a 4-word instance covers overflow.

module tb_imem_harness;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int MAXC  = 8;

  localparam int ST_CLEAR = 0;
  localparam int ST_IDLE  = 1;
  localparam int ST_LOAD  = 2;
  localparam int ST_RUN   = 3;
  localparam int ST_DONE  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        ld_valid = 1'b0;
  logic [15:0] ld_data  = '0;
  logic        ld_last  = 1'b0;
  logic        start    = 1'b0;
  logic        abort    = 1'b0;
  logic [15:0] pc       = '0;
  logic [15:0] pin_out  = '0;
  logic        ld_ready;
  logic [15:0] ins;
  logic        cpu_en;
  logic [2:0]  state;
  logic        halted;
  logic        timeout;
  logic        load_err;
  logic [10:0] prog_len;
  logic [31:0] cycles;

  logic        b_ld_valid = 1'b0;
  logic [15:0] b_ld_data  = '0;
  logic        b_ld_last  = 1'b0;
  logic        b_start    = 1'b0;
  logic        b_abort    = 1'b0;
  logic [15:0] b_pc       = '0;
  logic [15:0] b_pin_out  = '0;
  logic        b_ld_ready;
  logic [15:0] b_ins;
  logic        b_cpu_en;
  logic [2:0]  b_state;
  logic        b_halted;
  logic        b_timeout;
  logic        b_load_err;
  logic [2:0]  b_prog_len;
  logic [31:0] b_cycles;

  imem_harness #(
    .ADDR_W(AW), .INS_W(16), .PC_W(16),
    .HALT_BIT(0), .MAX_CYCLES(32'(MAXC))
  ) u_dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready),
    .start(start), .abort(abort),
    .pc(pc), .pin_out(pin_out),
    .ins(ins), .cpu_en(cpu_en), .state(state),
    .halted(halted), .timeout(timeout),
    .load_err(load_err), .prog_len(prog_len),
    .cycles(cycles)
  );

  imem_harness #(
    .ADDR_W(2), .INS_W(16), .PC_W(16),
    .HALT_BIT(0), .MAX_CYCLES(32'(MAXC))
  ) u_small (
    .clk(clk), .rst(rst),
    .ld_valid(b_ld_valid), .ld_data(b_ld_data),
    .ld_last(b_ld_last), .ld_ready(b_ld_ready),
    .start(b_start), .abort(b_abort),
    .pc(b_pc), .pin_out(b_pin_out),
    .ins(b_ins), .cpu_en(b_cpu_en), .state(b_state),
    .halted(b_halted), .timeout(b_timeout),
    .load_err(b_load_err), .prog_len(b_prog_len),
    .cycles(b_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] mref [DEPTH];
  int          m_wp;
  int          m_len;
  bit          m_err;
  int          m_st;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    int n;
    @(negedge clk);
    rst = 1'b1;
    ld_valid = 1'b0; ld_last = 1'b0;
    start = 1'b0; abort = 1'b0; pin_out = '0;
    b_ld_valid = 1'b0; b_start = 1'b0; b_pin_out = '0;
    @(negedge clk);
    chk("rst_state", 32'(state), ST_CLEAR);
    chk("rst_cpu_en", 32'(cpu_en), 0);
    chk("rst_ins", 32'(ins), 0);
    chk("rst_ld_ready", 32'(ld_ready), 0);
    chk("rst_flags", {29'd0, halted, timeout, load_err}, 0);
    chk("rst_prog_len", 32'(prog_len), 0);
    chk("rst_cycles", cycles, 0);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) mref[i] = '0;
    m_wp = 0; m_len = 0; m_err = 0; m_st = ST_IDLE;
    n = 0;
    while (state !== 3'(ST_IDLE) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("clear_len", 32'(n), DEPTH);
  endtask

  task automatic ld_word(input logic [15:0] d, input bit last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    #1;
    chk("ld_ready", 32'(ld_ready), 1);
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
    mref[m_wp] = d;
    if (m_st == ST_IDLE) m_err = 0;
    if (last) begin
      m_len = m_wp + 1; m_wp = 0; m_st = ST_IDLE;
    end else if (m_wp == DEPTH - 1) begin
      m_err = 1; m_len = DEPTH; m_wp = 0; m_st = ST_IDLE;
    end else begin
      m_wp++; m_st = ST_LOAD;
    end
    chk("ld_state", 32'(state), 32'(m_st));
    chk("ld_err", 32'(load_err), 32'(m_err));
    chk("ld_prog_len", 32'(prog_len), 32'(m_len));
  endtask

  // mode 0: random pc, 1: pc = 0,1,2..., 2: pc fixed 0x0401
  task automatic run(input int halt_at, input int abort_at, input int mode);
    int  k;
    bit  done;
    bit  exp_h;
    bit  exp_t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("run_state", 32'(state), ST_RUN);
    chk("run_cycles0", cycles, 0);
    chk("run_flags0", {30'd0, halted, timeout}, 0);
    chk("run_ld_ready", 32'(ld_ready), 0);
    k = 0;
    done = 0;
    while (!done) begin
      k++;
      if (mode == 0)      pc = 16'($urandom);
      else if (mode == 1) pc = 16'(k - 1);
      else                pc = 16'h0401;
      pin_out = (k == halt_at) ? 16'h0001 : (16'($urandom) & 16'hFFFE);
      abort = (k == abort_at);
      #1;
      chk("run_ins", 32'(ins), 32'(mref[pc[AW-1:0]]));
      chk("run_cpu_en", 32'(cpu_en), 1);
      @(negedge clk);
      pin_out = '0; abort = 1'b0;
      done = (k == halt_at) || (k >= MAXC) || (k == abort_at);
      if (!done) chk("run_continue", 32'(state), ST_RUN);
    end
    exp_h = (k == halt_at);
    exp_t = !exp_h && (k == MAXC);
    chk("done_state", 32'(state), ST_DONE);
    chk("done_halted", 32'(halted), 32'(exp_h));
    chk("done_timeout", 32'(timeout), 32'(exp_t));
    chk("done_cycles", cycles, 32'(k));
    chk("done_cpu_en", 32'(cpu_en), 0);
    chk("done_ins", 32'(ins), 0);
  endtask

  logic [15:0] w [6];
  logic [15:0] bexp [4];
  int          len;

  initial begin
    do_reset();

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", 32'(state), ST_IDLE);

    ld_word(16'h006F, 1'b0);
    ld_word(16'h6F00, 1'b1);
    chk("load_len2", 32'(prog_len), 2);

    run(3, 0, 1);

    ld_valid = 1'b1; ld_data = 16'hFFFF;
    #1;
    chk("done_ld_ready", 32'(ld_ready), 0);
    @(negedge clk);
    ld_valid = 1'b0;
    chk("done_ld_ignored", 32'(state), ST_DONE);

    run(0, 2, 1);
    run(0, 0, 2);
    run(MAXC, 0, 0);
    run(0, 0, 1);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrun_cycles", cycles, 5);
    do_reset();
    repeat (3) run(0, 0, 0);

    for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
    chk("small_idle", 32'(b_state), ST_IDLE);
    b_ld_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_ld_data = w[i]; b_ld_last = 1'b0;
      @(negedge clk);
      if (i == 3) begin
        chk("ovf_state", 32'(b_state), ST_IDLE);
        chk("ovf_err", 32'(b_load_err), 1);
        chk("ovf_len", 32'(b_prog_len), 4);
      end
    end
    chk("ovf_newload", 32'(b_state), ST_LOAD);
    chk("ovf_err_clr", 32'(b_load_err), 0);
    b_ld_data = w[5]; b_ld_last = 1'b1;
    @(negedge clk);
    b_ld_valid = 1'b0; b_ld_last = 1'b0;
    chk("ovf_len2", 32'(b_prog_len), 2);
    bexp[0] = w[4]; bexp[1] = w[5]; bexp[2] = w[2]; bexp[3] = w[3];
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b_pc = 16'(k + 4 * $urandom_range(0, 1000));
      b_pin_out = (k == 3) ? 16'h0001 : 16'h0000;
      #1;
      chk("small_ins", 32'(b_ins), 32'(bexp[k]));
      @(negedge clk);
    end
    b_pin_out = '0;
    chk("small_done", 32'(b_state), ST_DONE);
    chk("small_halted", 32'(b_halted), 1);
    chk("small_cycles", b_cycles, 4);

    repeat (3) begin
      do_reset();
      len = $urandom_range(2, 9);
      ld_word(16'($urandom), 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_in_load", 32'(state), ST_LOAD);
      for (int i = 1; i < len; i++)
        ld_word(16'($urandom), i == len - 1);
      repeat (3)
        run($urandom_range(1, 10), $urandom_range(1, 10), $urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
